led_pattern_engine: RTL and testbench
=====================================

Name: led_pattern_engine

Overview:
Consumes the 5-bit LED display-mode number (0..24) produced by the UART command decoder and drives an LED_NUM-wide LED bank with a timed animated pattern. It sits directly downstream of the decoder, and its mode input is wired to the decoder's mode output. The block contains a step prescaler, a mode-change detector and a per-mode pattern sequencer. Modes 10..19 repeat the patterns of modes 0..9 at double speed. Modes 20..24 are reserved.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
STEP_MS, 100, base step period in ms; STEP_CYC = (CLK_FREQ/1000)*STEP_MS clock cycles
LED_NUM, 8, LED bank width; the bit values in this spec are for LED_NUM=8

Ports:
I_clk  in  1  system clock; the block uses only this clock
I_rst  in  1  synchronous reset, active-high
I_mode  in  5  display-mode number from the UART decoder; may change on any cycle
O_led  out  LED_NUM  LED drive, 1 = lit, bit0 = rightmost LED
O_step  out  1  one-cycle pulse on each pattern step
O_mode_err  out  1  high while the active mode is reserved (20..24)

Behaviour:
- Reset values: O_led=0, O_step=0, O_mode_err=0, internal mode_q=0, prescaler=0, ping-pong direction=left.
- Reset takes priority over every other event, including mid-step and mid-pattern.
- Mode change:
  - Condition: I_mode != mode_q at a clock edge.
  - On that edge: mode_q<=I_mode, prescaler<=0, direction<=left, O_led<=INIT(I_mode), O_mode_err<=(I_mode>=20), O_step=0.
  - Latency is 1 clock from I_mode to O_led.
- Base pattern: p = mode_q if mode_q<10; p = mode_q-10 if 10<=mode_q<=19.
- Step limit: LIM = STEP_CYC for modes 0..9; LIM = STEP_CYC/2 for modes 10..19.
- Prescaler: counts 0..LIM-1. When it equals LIM-1 and there is no mode change on that edge:
  - prescaler<=0
  - O_step<=1 for exactly one cycle
  - O_led<=NEXT(p, O_led)
- Simultaneous step and mode change: the mode change wins and no O_step is issued.
- Patterns, listed as INIT then sequence (hex, LED_NUM=8):
  - p0 off: 00 constant. O_step still pulses.
  - p1 on: FF constant.
  - p2 blink: FF, 00, FF, ...
  - p3 run-left: 01, 02, 04 ... 80, 01 (rotate left, wraps).
  - p4 run-right: 80, 40 ... 01, 80.
  - p5 ping-pong: 01, 02 ... 80, 40 ... 01, 02 ... Direction flips on reaching the 80 end and the 01 end. The end values are not repeated.
  - p6 fill-up: 00, 01, 03, 07 ... FF, 00 (9-state cycle).
  - p7 fill-down: FF, 7F, 3F ... 00, FF.
  - p8 alternate: 55, AA, 55, ...
  - p9 binary count: 00, 01 ... FF, 00 (8-bit wrap).
- Modes 20..24: O_led=00, O_mode_err=1, prescaler frozen at 0, no O_step.
- Holding the same I_mode value does not restart the pattern.
- Widths: the prescaler is sized by $clog2(STEP_CYC). Every pattern arithmetic operation is modulo 2^LED_NUM.

Decomposition:
- Shared package led_mode_pkg holds:
  - mode constants MODE_OFF..MODE_CNT (0..9), MODE_FAST_BASE=10, MODE_RSVD_MIN=20
  - the LED_NUM default
  - pure functions pattern_init(p) and pattern_next(p, cur, dir)
- Natural sub-module led_step_timer: the prescaler with inputs limit, restart and hold, and the output step pulse.

Test Plan:
- Override CLK_FREQ=1000, STEP_MS=4, so STEP_CYC=4 (fast modes use 2).
- Reset with I_rst=1 for 3 cycles and I_mode=3 -> O_led=00, O_step=0, O_mode_err=0. After release, O_led=01 one cycle later, then 02, 04 at 4-cycle intervals with an O_step pulse at each change.
- I_mode=5, run 16 steps -> O_led = 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02. No duplicated end values.
- I_mode=13 -> O_led=01 one cycle after the change, then rotates every 2 cycles. Switching to I_mode=3 restarts at 01 with a 4-cycle step.
- Change I_mode 6->9 on the same edge the prescaler reaches LIM-1 -> no O_step that cycle, O_led=00, next step at +4 cycles gives 01.
- I_mode=22 -> O_led=00 and O_mode_err=1 after 1 cycle, with no O_step for 20 cycles. Then I_mode=2 -> O_mode_err=0 and O_led=FF.
- In mode 9, run 256 steps -> O_led wraps FF->00. Assert I_rst mid-step -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/led_mode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_mode_pkg
// Description : Shared definitions for the LED pattern engine. It holds the
//               display-mode numbers, the step direction type and the pure
//               pattern functions (initial value, next value, next direction).
//               The pattern functions work on a fixed LED_MAX-bit container
//               and take the live bank width as an argument. Callers keep
//               the low bits.
// Revision    : 1.0 - initial release
// ============================================================================
package led_mode_pkg;

    localparam int unsigned LED_NUM_DEF = 8;
    // Widest LED bank the pattern functions can handle.
    localparam int unsigned LED_MAX     = 32;

    localparam logic [4:0] MODE_OFF       = 5'd0;
    localparam logic [4:0] MODE_ON        = 5'd1;
    localparam logic [4:0] MODE_BLINK     = 5'd2;
    localparam logic [4:0] MODE_RUN_L     = 5'd3;
    localparam logic [4:0] MODE_RUN_R     = 5'd4;
    localparam logic [4:0] MODE_PING      = 5'd5;
    localparam logic [4:0] MODE_FILL_UP   = 5'd6;
    localparam logic [4:0] MODE_FILL_DN   = 5'd7;
    localparam logic [4:0] MODE_ALT       = 5'd8;
    localparam logic [4:0] MODE_CNT       = 5'd9;
    localparam logic [4:0] MODE_FAST_BASE = 5'd10;
    localparam logic [4:0] MODE_RSVD_MIN  = 5'd20;

    typedef logic [3:0]         pattern_t;
    typedef logic [LED_MAX-1:0] led_vec_t;
    typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

    function automatic logic mode_is_reserved(input logic [4:0] m);
        return (m >= MODE_RSVD_MIN);
    endfunction

    function automatic logic mode_is_fast(input logic [4:0] m);
        return (m >= MODE_FAST_BASE) && (m < MODE_RSVD_MIN);
    endfunction

    // Fast modes reuse the base patterns. Reserved modes map to "off".
    function automatic pattern_t mode_to_pattern(input logic [4:0] m);
        if (m < MODE_FAST_BASE)
            return pattern_t'(m);
        else if (m < MODE_RSVD_MIN)
            return pattern_t'(m - MODE_FAST_BASE);
        else
            return pattern_t'(0);
    endfunction

    function automatic led_vec_t led_mask(input int unsigned n);
        return {LED_MAX{1'b1}} >> (LED_MAX - n);
    endfunction

    function automatic led_vec_t led_msb(input int unsigned n);
        return led_vec_t'(1) << (n - 1);
    endfunction

    function automatic led_vec_t pattern_init(input pattern_t p, input int unsigned n);
        led_vec_t mask;
        mask = led_mask(n);
        case ({1'b0, p})
            MODE_ON, MODE_BLINK, MODE_FILL_DN: return mask;
            MODE_RUN_L, MODE_PING:             return led_vec_t'(1);
            MODE_RUN_R:                        return led_msb(n);
            MODE_ALT:                          return {(LED_MAX/2){2'b01}} & mask;
            default:                           return '0;
        endcase
    endfunction

    function automatic led_vec_t pattern_next(input pattern_t p, input led_vec_t cur,
                                              input dir_t dir, input int unsigned n);
        led_vec_t mask;
        mask = led_mask(n);
        case ({1'b0, p})
            MODE_OFF:          return '0;
            MODE_ON:           return mask;
            MODE_BLINK,
            MODE_ALT:          return ~cur & mask;
            MODE_RUN_L:        return ((cur << 1) | (cur >> (n - 1))) & mask;
            MODE_RUN_R:        return (cur >> 1) | ((cur & led_vec_t'(1)) << (n - 1));
            MODE_PING:         return (dir == DIR_LEFT) ? ((cur << 1) & mask) : (cur >> 1);
            MODE_FILL_UP:      return (cur == mask) ? '0 : (((cur << 1) | led_vec_t'(1)) & mask);
            MODE_FILL_DN:      return (cur == '0) ? mask : (cur >> 1);
            MODE_CNT:          return (cur + led_vec_t'(1)) & mask;
            default:           return '0;
        endcase
    endfunction

    // The ping-pong direction turns around as soon as the new value lands on
    // an end LED. Each end is therefore shown once per sweep, not twice.
    function automatic dir_t pattern_dir_next(input pattern_t p, input led_vec_t nxt,
                                              input dir_t dir, input int unsigned n);
        if ({1'b0, p} != MODE_PING)
            return dir;
        if ((dir == DIR_LEFT) && (nxt == led_msb(n)))
            return DIR_RIGHT;
        if ((dir == DIR_RIGHT) && (nxt == led_vec_t'(1)))
            return DIR_LEFT;
        return dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : led_step_timer
// Description : Step prescaler. It counts 0..limit-1 and raises a
//               combinational tick on the last count. It also produces a
//               registered one-cycle step pulse one cycle after the tick
//               edge. A restart or hold forces the counter to zero and
//               suppresses the tick.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               limit         - step length in cycles (>= 1)
//               restart       - clear the count (mode change)
//               hold          - freeze the count at zero (reserved mode)
//               tick          - this edge ends a step (combinational)
//               step          - registered one-cycle step pulse
// Revision    : 1.0 - initial release
// ============================================================================
module led_step_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CNT_W:0] limit,
    input  logic           restart,
    input  logic           hold,
    output logic           tick,
    output logic           step
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_step;
    logic             w_at_end;

    assign w_at_end = ({1'b0, r_cnt} == (limit - 1'b1));
    assign tick     = w_at_end & ~restart & ~hold;
    assign step     = r_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_step <= 1'b0;
        end else begin
            r_step <= tick;
            if (restart || hold || tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_engine
// Description : Drives an LED bank with a timed animated pattern selected by
//               the 5-bit display-mode number from the UART decoder.
//               Modes 0..9 are the base patterns. Modes 10..19 show the same
//               patterns at double speed. Modes 20..24 (and above) are
//               reserved: the LEDs stay dark and the error flag is set.
// Ports       : I_clk      - system clock
//               I_rst      - synchronous active-high reset
//               I_mode     - display-mode number, may change on any cycle
//               O_led      - LED drive, 1 = lit, bit0 = rightmost
//               O_step     - one-cycle pulse on each pattern step
//               O_mode_err - high while the active mode is reserved
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_engine
    import led_mode_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned STEP_MS  = 100,
    parameter int unsigned LED_NUM  = LED_NUM_DEF  // must not exceed LED_MAX
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic [4:0]         I_mode,
    output logic [LED_NUM-1:0] O_led,
    output logic               O_step,
    output logic               O_mode_err
);

    localparam int unsigned STEP_CYC = (CLK_FREQ / 1000) * STEP_MS;
    localparam int unsigned CNT_W    = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int unsigned LIM_W    = CNT_W + 1;
    localparam int unsigned FAST_CYC = (STEP_CYC / 2 > 0) ? STEP_CYC / 2 : 1;

    localparam logic [LIM_W-1:0] C_LIM_SLOW = LIM_W'(STEP_CYC);
    localparam logic [LIM_W-1:0] C_LIM_FAST = LIM_W'(FAST_CYC);

    logic [4:0]         r_mode;
    dir_t               r_dir;
    logic [LED_NUM-1:0] r_led;
    logic               r_mode_err;

    logic               w_mode_change;
    logic               w_hold;
    logic               w_tick;
    logic               w_step;
    logic [LIM_W-1:0]   w_limit;
    pattern_t           w_pat;
    led_vec_t           w_init_full;
    led_vec_t           w_next_full;
    dir_t               w_dir_next;

    assign w_mode_change = (I_mode != r_mode);
    assign w_hold        = mode_is_reserved(r_mode);
    assign w_limit       = mode_is_fast(r_mode) ? C_LIM_FAST : C_LIM_SLOW;
    assign w_pat         = mode_to_pattern(r_mode);

    // The initial value is computed from the incoming mode, because it is
    // loaded on the same edge that the mode register is updated.
    assign w_init_full   = pattern_init(mode_to_pattern(I_mode), LED_NUM);
    assign w_next_full   = pattern_next(w_pat, led_vec_t'(r_led), r_dir, LED_NUM);
    assign w_dir_next    = pattern_dir_next(w_pat, w_next_full, r_dir, LED_NUM);

    // The pattern functions mask their results to LED_NUM bits. The upper
    // container bits are always zero and are not used.
    generate
        if (LED_NUM < LED_MAX) begin : g_trim
            logic w_unused_hi;
            assign w_unused_hi = ^{w_init_full[LED_MAX-1:LED_NUM],
                                   w_next_full[LED_MAX-1:LED_NUM]};
        end
    endgenerate

    led_step_timer #(
        .CNT_W   (CNT_W)
    ) u_step_timer (
        .clk     (I_clk),
        .rst     (I_rst),
        .limit   (w_limit),
        .restart (w_mode_change),
        .hold    (w_hold),
        .tick    (w_tick),
        .step    (w_step)
    );

    // A mode change takes precedence over a step on the same edge. The
    // timer already masks its tick when restart is asserted.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_mode     <= 5'd0;
            r_dir      <= DIR_LEFT;
            r_led      <= '0;
            r_mode_err <= 1'b0;
        end else if (w_mode_change) begin
            r_mode     <= I_mode;
            r_dir      <= DIR_LEFT;
            r_led      <= mode_is_reserved(I_mode) ? '0 : w_init_full[LED_NUM-1:0];
            r_mode_err <= mode_is_reserved(I_mode);
        end else if (w_tick) begin
            r_led      <= w_next_full[LED_NUM-1:0];
            r_dir      <= w_dir_next;
        end
    end

    assign O_led      = r_led;
    assign O_step     = w_step;
    assign O_mode_err = r_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_engine
// Description : Self-checking bench for led_pattern_engine with
//               CLK_FREQ=1000 and STEP_MS=4, giving 4-cycle steps
//               (2 cycles in fast modes). A reference model keeps the
//               current mode, the phase within the step and the step index
//               k. It computes the expected LED value directly as a
//               closed-form function of pattern and k. Directed scenarios are
//               followed by randomized mode/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_engine;

    logic       clk = 1'b0;
    logic       I_rst;
    logic [4:0] I_mode;
    logic [7:0] O_led;
    logic       O_step;
    logic       O_mode_err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int         m_mode = 0;
    int         m_cyc  = 0;
    int         m_k    = 0;
    logic [7:0] e_led  = 8'h00;
    logic       e_step = 1'b0;
    logic       e_err  = 1'b0;

    always #5 clk = ~clk;

    led_pattern_engine #(
        .CLK_FREQ   (1000),
        .STEP_MS    (4),
        .LED_NUM    (8)
    ) dut (
        .I_clk      (clk),
        .I_rst      (I_rst),
        .I_mode     (I_mode),
        .O_led      (O_led),
        .O_step     (O_step),
        .O_mode_err (O_mode_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // LED value after k steps of base pattern p, written as a closed form.
    function automatic logic [7:0] led_at(input int p, input int k);
        int j;
        case (p)
            0: return 8'h00;
            1: return 8'hFF;
            2: return (k % 2 == 0) ? 8'hFF : 8'h00;
            3: return 8'(1 << (k % 8));
            4: return 8'(128 >> (k % 8));
            5: begin
                j = k % 14;
                return (j <= 7) ? 8'(1 << j) : 8'(1 << (14 - j));
            end
            6: return 8'((1 << (k % 9)) - 1);
            7: return 8'(255 >> (k % 9));
            8: return (k % 2 == 0) ? 8'h55 : 8'hAA;
            default: return 8'(k % 256);
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic [4:0] mode);
        if (rst) begin
            m_mode = 0; m_cyc = 0; m_k = 0; e_step = 1'b0;
        end else if (int'(mode) != m_mode) begin
            m_mode = int'(mode); m_cyc = 0; m_k = 0; e_step = 1'b0;
        end else if (m_mode >= 20) begin
            e_step = 1'b0;
        end else begin
            m_cyc++;
            if (m_cyc == ((m_mode >= 10) ? 2 : 4)) begin
                m_cyc = 0; m_k++; e_step = 1'b1;
            end else begin
                e_step = 1'b0;
            end
        end
        e_err = (m_mode >= 20);
        e_led = (m_mode >= 20) ? 8'h00 : led_at(m_mode % 10, m_k);
    endtask

    // One clock: drive inputs, advance model at the edge, check mid-cycle.
    task automatic cyc(input logic rst, input logic [4:0] mode);
        I_rst  = rst;
        I_mode = mode;
        @(posedge clk);
        model_edge(rst, mode);
        @(negedge clk);
        check("led",  O_led,            e_led);
        check("step", 8'(O_step),       8'(e_step));
        check("err",  8'(O_mode_err),   8'(e_err));
    endtask

    initial begin
        logic [4:0] rmode;
        int         rlen;

        I_rst  = 1'b1;
        I_mode = 5'd3;
        @(negedge clk);

        // reset with mode 3 waiting, then run-left
        repeat (3) cyc(1'b1, 5'd3);
        check("rst_led", O_led, 8'h00);
        cyc(1'b0, 5'd3);
        check("rl_first", O_led, 8'h01);
        repeat (8) cyc(1'b0, 5'd3);
        check("rl_third", O_led, 8'h04);

        // ping-pong, 16 values
        cyc(1'b0, 5'd5);
        repeat (60) cyc(1'b0, 5'd5);
        check("pp_16th", O_led, 8'h02);

        // fast run-left, then back to normal speed
        cyc(1'b0, 5'd13);
        check("fast_init", O_led, 8'h01);
        repeat (2) cyc(1'b0, 5'd13);
        check("fast_step", O_led, 8'h02);
        cyc(1'b0, 5'd3);
        check("slow_init", O_led, 8'h01);
        repeat (3) cyc(1'b0, 5'd3);
        check("slow_hold", O_led, 8'h01);
        cyc(1'b0, 5'd3);
        check("slow_step", O_led, 8'h02);

        // mode change on the edge where a step would occur
        cyc(1'b0, 5'd6);
        repeat (3) cyc(1'b0, 5'd6);
        cyc(1'b0, 5'd9);
        check("coll_step", 8'(O_step), 8'h00);
        check("coll_led", O_led, 8'h00);
        repeat (4) cyc(1'b0, 5'd9);
        check("coll_next", O_led, 8'h01);

        // reserved mode, then blink
        cyc(1'b0, 5'd22);
        check("rsvd_err", 8'(O_mode_err), 8'h01);
        repeat (20) cyc(1'b0, 5'd22);
        cyc(1'b0, 5'd2);
        check("blink_init", O_led, 8'hFF);
        check("blink_err", 8'(O_mode_err), 8'h00);

        // binary count through the 8-bit wrap
        cyc(1'b0, 5'd9);
        repeat (255 * 4) cyc(1'b0, 5'd9);
        check("cnt_ff", O_led, 8'hFF);
        repeat (4) cyc(1'b0, 5'd9);
        check("cnt_wrap", O_led, 8'h00);

        // reset mid-step
        repeat (6) cyc(1'b0, 5'd9);
        cyc(1'b1, 5'd9);
        check("rst_mid_led", O_led, 8'h00);
        check("rst_mid_step", 8'(O_step), 8'h00);

        // randomized mode sequences with occasional resets
        repeat (300) begin
            if ($urandom_range(0, 9) == 0)
                rmode = 5'($urandom_range(20, 24));
            else
                rmode = 5'($urandom_range(0, 19));
            rlen = int'($urandom_range(1, 30));
            for (int i = 0; i < rlen; i++)
                cyc(($urandom_range(0, 199) == 0), rmode);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
